// File: rtl/decimal_bcd_entry_encoder.sv
// Decimal keypad entry into a shifting BCD working register, with a
// publish/acknowledge handshake for the finished value.
module decimal_bcd_entry_encoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned PRIORITY_MODE = 0,
  localparam int unsigned CW           = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            key,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic                  enter,
  input  logic                  clear,
  input  logic                  out_ack,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic [CW-1:0]         digit_count,
  output logic                  err
);

  localparam int unsigned WW = 4 * DIGITS;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   entry_q, entry_d;
  logic [WW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic            ready_c;
  logic            dec_ok;
  logic [3:0]      dec_digit;
  logic            accept;
  logic            take;
  logic            full_after;
  logic [WW-1:0]   work;
  logic [CW-1:0]   work_cnt;

  // Key decode; ascending scan leaves the highest set bit as the digit.
  always_comb begin
    dec_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key[i]) dec_digit = 4'(i);
    end
    dec_ok = (PRIORITY_MODE != 0) ? (key != 10'd0) : $onehot(key);
    accept     = key_valid && ready_c;
    take       = accept && dec_ok;
    work       = take ? ((entry_q << 4) | WW'(dec_digit)) : entry_q;
    work_cnt   = take ? (count_q + CW'(1)) : count_q;
    full_after = (work_cnt == CW'(DIGITS));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides every other input.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (take) state_d = enter ? DONE : (full_after ? FULL : ENTRY);
        ENTRY: begin
          if (enter)                   state_d = DONE;
          else if (take && full_after) state_d = FULL;
        end
        FULL:  if (enter)   state_d = DONE;
        DONE:  if (out_ack) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output and datapath next values; a same-cycle key is shifted in before publish.
  always_comb begin
    ready_c = (state_q == EMPTY) || (state_q == ENTRY);
    entry_d = entry_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (clear) begin
      entry_d = '0;
      bcd_d   = '0;
      count_d = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY, ENTRY: begin
          err_d   = accept && !dec_ok;
          entry_d = work;
          count_d = work_cnt;
          if (enter && (take || state_q == ENTRY)) begin
            bcd_d   = work;
            valid_d = 1'b1;
          end
        end
        FULL: begin
          if (enter) begin
            bcd_d   = entry_q;
            valid_d = 1'b1;
          end
        end
        DONE: begin
          if (out_ack) begin
            valid_d = 1'b0;
            entry_d = '0;
            count_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign key_ready   = ready_c;
  assign entry_bcd   = entry_q;
  assign bcd_out     = bcd_q;
  assign digit_count = count_q;
  assign out_valid   = valid_q;
  assign err         = err_q;

endmodule

// File: doc/decimal_bcd_entry_encoder.md
DECIMAL_BCD_ENTRY_ENCODER -- requirements
Module: decimal_bcd_entry_encoder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DIGITS, 4, number of BCD digits held (legal 1..8).
- PRIORITY_MODE, 0, key decoding: 0 = strict one-hot; 1 = highest set bit wins.
REQ-002 Derived width CW = clog2(DIGITS+1) SHALL be used for digit_count.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- key, in, 10, decimal key vector; bit i = digit i.
- key_valid, in, 1, key is presented.
- key_ready, out, 1, block can accept a key.
- enter, in, 1, finish entry and publish value.
- clear, in, 1, synchronous abort of entry and result.
- out_ack, in, 1, consumer accepted result.
- entry_bcd, out, 4*DIGITS, live working register; digit 0 in bits [3:0].
- bcd_out, out, 4*DIGITS, published result.
- out_valid, out, 1, bcd_out is valid and awaiting ack.
- digit_count, out, CW, digits in working register.
- err, out, 1, one-cycle pulse on a rejected key.
REQ-004 Clock is clk; reset is rst_n, asynchronous assert, active-low; no other clock or reset exists.

Function
REQ-005 FSM states SHALL be EMPTY, ENTRY, FULL, DONE.
REQ-006 key_ready = 1 in EMPTY and ENTRY; 0 in FULL and DONE.
REQ-007 Key accepted when key_valid && key_ready.
REQ-008 Decode, strict mode: exactly one bit set -> digit = index (bit0->0 ... bit9->9); zero or multiple bits set -> invalid.
REQ-009 Decode, priority mode: highest set bit index wins; key == 0 -> invalid.
REQ-010 Valid accepted key: entry_bcd shifts left one nibble (top nibble discarded), new digit enters [3:0], digit_count+1; visible the next cycle.
REQ-011 Invalid accepted key: entry_bcd and digit_count unchanged; err = 1 for exactly the next cycle.
REQ-012 err SHALL be 0 in all other cycles; key_valid with key_ready = 0 is ignored and SHALL NOT raise err.
REQ-013 Transitions:
- EMPTY -> ENTRY on the first valid digit.
- ENTRY -> FULL when digit_count reaches DIGITS.
- ENTRY or FULL -> DONE on enter.
- DONE -> EMPTY on out_ack.
REQ-014 enter in ENTRY/FULL: bcd_out takes the working value and out_valid = 1 on the next cycle (latency 1).
REQ-015 Same-cycle valid key and enter in EMPTY/ENTRY: the key is shifted in first and is included in bcd_out.
REQ-016 enter in EMPTY with no valid digit accepted that cycle SHALL be ignored.
REQ-017 enter in DONE is ignored.
REQ-018 DONE: out_valid held at 1 until out_ack. On out_ack: next cycle out_valid = 0, entry_bcd = 0, digit_count = 0, state EMPTY. bcd_out retains its value.
REQ-019 clear has highest priority over key, enter and out_ack. Next cycle: entry_bcd = 0, bcd_out = 0, digit_count = 0, out_valid = 0, err = 0, state EMPTY.
REQ-020 out_ack while out_valid = 0 SHALL be ignored.
REQ-021 Every entry_bcd and bcd_out nibble SHALL always lie in 0..9.

Reset
REQ-022 While rst_n = 0 (asynchronous), the block SHALL hold: state EMPTY, entry_bcd = 0, bcd_out = 0, digit_count = 0, out_valid = 0, err = 0, key_ready = 1 (combinational from EMPTY).
REQ-023 Reset asserted mid-entry or in DONE SHALL discard all digits and the pending result; operation resumes on the first edge after release.

Verification
REQ-024 DIGITS=4, strict. Keys 0x008, 0x001, 0x200, then enter -> entry_bcd = 0x0309, digit_count = 3, next cycle bcd_out = 0x0309, out_valid = 1.
REQ-025 Strict mode, key = 0x006 -> err pulses 1 cycle, entry_bcd and digit_count unchanged. Same key with PRIORITY_MODE=1 -> digit 2 accepted.
REQ-026 DIGITS=4. Five valid keys 1,2,3,4,5 -> after 4 keys key_ready = 0, digit_count = 4, entry_bcd = 0x1234. Fifth key ignored with no err.
REQ-027 Valid key 7 and enter in the same ENTRY cycle after digit 5 -> bcd_out = 0x0057. Hold out_ack = 0 for 3 cycles -> out_valid stays 1. out_ack -> EMPTY, digit_count = 0.
REQ-028 clear together with enter and a valid key -> all outputs 0 next cycle, state EMPTY.
REQ-029 rst_n pulsed low mid-cycle during entry -> outputs 0 immediately, without waiting for a clock edge.
